// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB camera-init master.
package sccb_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      FETCH,
      START,
      BIT,
      STOP,
      GAP,
      DELAY,
      DONE
   } state_t;

   localparam logic [15:0] TBL_END      = 16'hFFFF;
   localparam logic [15:0] TBL_DELAY    = 16'hFFF0;
   localparam logic [7:0]  DEV_ADDR_DEF = 8'h42;

   localparam int unsigned IDX_W      = 3;
   localparam int unsigned FRAME_BITS = 27;

endpackage

// File: rtl/sccb_init_rom.sv
// Camera init table: {reg, val} per entry, with delay/end sentinels.
module sccb_init_rom
   import sccb_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [15:0]      entry_c
);

   // Fixed register/value sequence, terminated by TBL_END
   always_comb begin
      entry_c = TBL_END;
      unique case (idx)
         3'd0:    entry_c = 16'h1280;
         3'd1:    entry_c = TBL_DELAY;
         3'd2:    entry_c = 16'h1204;
         3'd3:    entry_c = 16'h1101;
         3'd4:    entry_c = 16'h0C00;
         3'd5:    entry_c = 16'h3E00;
         3'd6:    entry_c = 16'h40D0;
         default: entry_c = TBL_END;
      endcase
   end

endmodule

// File: rtl/sccb_if.sv
// SCCB write-only master: walks the init table after reset, then raises init_done.
module sccb_if
   import sccb_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
   parameter int unsigned SCL_FREQ_HZ  = 100_000,
   parameter logic [7:0]  DEV_ADDR     = DEV_ADDR_DEF,
   parameter int unsigned PWRUP_CYCLES = 25_000,
   parameter int unsigned DELAY_CYCLES = 250_000
) (
   input  logic clk_25,
   input  logic rst,
   output logic scl,
   output logic sda,
   output logic init_done
);

   localparam int unsigned QUARTER = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
   localparam int unsigned MAX_PD  = (DELAY_CYCLES > PWRUP_CYCLES) ? DELAY_CYCLES : PWRUP_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_PD > QUARTER) ? MAX_PD : QUARTER;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = $clog2(FRAME_BITS);

   state_t                  state, state_n;
   logic [CNT_W-1:0]        cnt, cnt_n;
   logic [1:0]              qn, qn_n;
   logic [BIT_W-1:0]        bitn, bitn_n;
   logic [IDX_W-1:0]        idx, idx_n;
   logic                    scl_n, sda_n, done_n;
   logic [15:0]             entry_c;
   logic [FRAME_BITS-1:0]   frame_c;
   logic                    q_end_c;
   logic                    q0_first_c;

   sccb_init_rom u_rom (
      .idx     (idx),
      .entry_c (entry_c)
   );

   // Three 9-bit phases: ID, reg, val, each followed by a driven-high don't-care bit
   assign frame_c    = {DEV_ADDR, 1'b1, entry_c[15:8], 1'b1, entry_c[7:0], 1'b1};
   assign q_end_c    = (cnt == CNT_W'(QUARTER - 1));
   // First cycle of q0: scl falls here, so sda holds one cycle to avoid a simultaneous edge
   assign q0_first_c = (qn == 2'd0) && (cnt == '0);

   // State, counters and registered bus outputs
   always_ff @(posedge clk_25 or negedge rst) begin
      if (!rst) begin
         state     <= PWRUP;
         cnt       <= '0;
         qn        <= '0;
         bitn      <= '0;
         idx       <= '0;
         scl       <= 1'b1;
         sda       <= 1'b1;
         init_done <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         qn        <= qn_n;
         bitn      <= bitn_n;
         idx       <= idx_n;
         scl       <= scl_n;
         sda       <= sda_n;
         init_done <= done_n;
      end
   end

   // Next-state, quarter sequencing and next bus levels
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CNT_W'(1);
      qn_n    = qn;
      bitn_n  = bitn;
      idx_n   = idx;
      scl_n   = 1'b1;
      sda_n   = 1'b1;
      done_n  = init_done;

      unique case (state)
         PWRUP: begin
            if (cnt == CNT_W'(PWRUP_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = FETCH;
            end
         end
         FETCH: begin
            cnt_n  = '0;
            qn_n   = '0;
            bitn_n = BIT_W'(FRAME_BITS - 1);
            if (entry_c == TBL_END) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else if (entry_c == TBL_DELAY) begin
               state_n = DELAY;
            end else begin
               state_n = START;
            end
         end
         START: begin
            sda_n = (qn == 2'd0);
            if (q_end_c) begin
               cnt_n = '0;
               if (qn == 2'd2) begin
                  qn_n    = '0;
                  state_n = BIT;
               end else begin
                  qn_n = qn + 2'd1;
               end
            end
         end
         BIT: begin
            scl_n = qn[1];
            sda_n = q0_first_c ? sda : frame_c[bitn];
            if (q_end_c) begin
               cnt_n = '0;
               qn_n  = qn + 2'd1;
               if (qn == 2'd3) begin
                  if (bitn == '0) begin
                     state_n = STOP;
                  end else begin
                     bitn_n = bitn - BIT_W'(1);
                  end
               end
            end
         end
         STOP: begin
            scl_n = (qn != 2'd0);
            sda_n = q0_first_c ? sda : 1'b0;
            if (q_end_c) begin
               cnt_n = '0;
               if (qn == 2'd1) begin
                  qn_n    = '0;
                  state_n = GAP;
               end else begin
                  qn_n = qn + 2'd1;
               end
            end
         end
         GAP: begin
            if (q_end_c) begin
               cnt_n = '0;
               qn_n  = qn + 2'd1;
               if (qn == 2'd3) begin
                  idx_n   = idx + IDX_W'(1);
                  state_n = FETCH;
               end
            end
         end
         DELAY: begin
            if (cnt == CNT_W'(DELAY_CYCLES - 1)) begin
               cnt_n   = '0;
               idx_n   = idx + IDX_W'(1);
               state_n = FETCH;
            end
         end
         DONE: begin
            cnt_n = cnt;
         end
         default: begin
            state_n = PWRUP;
         end
      endcase
   end

endmodule

// File: tb/tb_sccb_if.sv
// Directed bench for sccb_if: bus decode, timing, sticky done and reset abort.
`define CHECK(tag, obs, exp) \
   begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
         errors++; \
         $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
      end \
   end

module tb_sccb_if;

   localparam int Q   = 10;     // 4 MHz / (4 * 100 kHz)
   localparam int PWR = 300;
   localparam int DLY = 1500;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic scl, sda, init_done;

   int checks = 0;
   int errors = 0;

   sccb_if #(
      .CLK_FREQ_HZ  (4_000_000),
      .SCL_FREQ_HZ  (100_000),
      .DEV_ADDR     (8'h42),
      .PWRUP_CYCLES (PWR),
      .DELAY_CYCLES (DLY)
   ) dut (
      .clk_25    (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   // Bus monitor state
   logic        prev_scl = 1'b1;
   logic        prev_sda = 1'b1;
   logic        in_txn   = 1'b0;
   logic [27:0] shreg    = '0;
   int cyc = 0, ntx = 0, bitcnt = 0, run = 0;
   int hi_bad = 0, lo_bad = 0, toggle_bad = 0;
   logic [26:0] frames [8];
   int start_cyc [8];
   int stop_cyc  [8];
   int hold_len  [8];

   // Decode START/STOP framing, sample bits on scl rise, time the scl halves
   always @(negedge clk) begin
      if (!rst) begin
         prev_scl = 1'b1;
         prev_sda = 1'b1;
         in_txn   = 1'b0;
         shreg    = '0;
         cyc      = 0;
         ntx      = 0;
         bitcnt   = 0;
         run      = 0;
      end else begin
         cyc++;
         if (scl != prev_scl) begin
            if (!scl && in_txn && bitcnt >= 1 && run != 2*Q) hi_bad++;
            if (scl && in_txn && bitcnt < 27 && run != 2*Q) lo_bad++;
            if (!scl && in_txn && bitcnt == 0 && ntx < 8) hold_len[3'(ntx)] = cyc - start_cyc[3'(ntx)];
            if (scl && in_txn) begin
               shreg = {shreg[26:0], sda};
               bitcnt++;
            end
            run = 1;
         end else begin
            run++;
         end
         if (scl && prev_scl && sda != prev_sda) begin
            if (!sda) begin
               if (in_txn) toggle_bad++;
               in_txn = 1'b1;
               bitcnt = 0;
               if (ntx < 8) start_cyc[3'(ntx)] = cyc;
            end else if (in_txn && bitcnt == 28) begin
               if (ntx < 8) begin
                  frames[3'(ntx)]   = shreg[27:1];
                  stop_cyc[3'(ntx)] = cyc;
               end
               ntx++;
               in_txn = 1'b0;
            end else begin
               toggle_bad++;
            end
         end
         prev_scl = scl;
         prev_sda = sda;
      end
   end

   function automatic logic [26:0] exp_frame(input logic [7:0] r, input logic [7:0] v);
      return {8'h42, 1'b1, r, 1'b1, v, 1'b1};
   endfunction

   logic [7:0] er [8];
   logic [7:0] ev [8];

   initial begin
      logic ok;
      er[0] = 8'h12; ev[0] = 8'h80;
      er[1] = 8'h12; ev[1] = 8'h04;
      er[2] = 8'h11; ev[2] = 8'h01;
      er[3] = 8'h0C; ev[3] = 8'h00;
      er[4] = 8'h3E; ev[4] = 8'h00;
      er[5] = 8'h40; ev[5] = 8'hD0;
      er[6] = 8'h00; ev[6] = 8'h00;
      er[7] = 8'h00; ev[7] = 8'h00;

      // Reset state
      #23;
      `CHECK("reset_scl", scl, 1'b1)
      `CHECK("reset_sda", sda, 1'b1)
      `CHECK("reset_done", init_done, 1'b0)

      // Run 1: full table
      @(negedge clk); #2 rst = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge clk);
         ok = (ntx == 6);
      end
      `CHECK("run1_six_txn_seen", ok, 1'b1)
      `CHECK("run1_done_low_at_last_stop", init_done, 1'b0)
      repeat (6*Q) @(negedge clk);
      `CHECK("run1_done_high", init_done, 1'b1)
      `CHECK("run1_pwrup_idle", (start_cyc[0] >= PWR), 1'b1)
      for (int k = 0; k < 6; k++) begin
         `CHECK("run1_frame", frames[3'(k)], exp_frame(er[3'(k)], ev[3'(k)]))
         `CHECK("run1_start_hold", hold_len[3'(k)], 2*Q)
      end
      // GAP 4Q + fetch + DELAY + fetch + START's idle quarter
      `CHECK("run1_delay_gap", (start_cyc[1] - stop_cyc[0]), DLY + 5*Q + 2)
      // GAP 4Q + fetch + START's idle quarter
      for (int k = 1; k < 5; k++) begin
         `CHECK("run1_gap", (start_cyc[3'(k+1)] - stop_cyc[3'(k)]), 5*Q + 1)
      end
      repeat (2000) @(negedge clk);
      `CHECK("run1_done_sticky", init_done, 1'b1)
      `CHECK("run1_no_extra_txn", ntx, 6)
      `CHECK("run1_idle_scl", scl, 1'b1)
      `CHECK("run1_idle_sda", sda, 1'b1)

      // Async reset while done
      #2 rst = 1'b0;
      #1;
      `CHECK("rst_done_clears", init_done, 1'b0)
      `CHECK("rst_done_scl", scl, 1'b1)
      `CHECK("rst_done_sda", sda, 1'b1)

      // Run 2: abort inside the third transaction's data phase
      @(negedge clk); #2 rst = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge clk);
         ok = (ntx == 2) && in_txn && (bitcnt >= 19) && !scl && !sda;
      end
      `CHECK("run2_reached_txn3_data", ok, 1'b1)
      #2 rst = 1'b0;
      #1;
      `CHECK("abort_scl", scl, 1'b1)
      `CHECK("abort_sda", sda, 1'b1)
      `CHECK("abort_done", init_done, 1'b0)

      // Run 3: sequence restarts from power-up
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 8000 && !ok; i++) begin
         @(negedge clk);
         ok = (ntx == 1);
      end
      `CHECK("run3_first_txn_seen", ok, 1'b1)
      `CHECK("run3_frame", frames[0], exp_frame(8'h12, 8'h80))
      `CHECK("run3_pwrup_idle", (start_cyc[0] >= PWR), 1'b1)
      `CHECK("run3_done_low", init_done, 1'b0)

      // Bus-rule violations accumulated over all runs
      `CHECK("sda_toggle_while_scl_high", toggle_bad, 0)
      `CHECK("scl_high_half", hi_bad, 0)
      `CHECK("scl_low_half", lo_bad, 0)

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
